// File: rtl/alu_pkg.sv
// Shared opcode/state types and opcode-group decode tables for alu_seq.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD    = 4'h0,
    OP_SUB    = 4'h1,
    OP_SHL1   = 4'h2,
    OP_ROR1   = 4'h3,
    OP_AND    = 4'h4,
    OP_OR     = 4'h5,
    OP_XOR    = 4'h6,
    OP_NOT    = 4'h7,
    OP_ADC    = 4'h8,
    OP_SBC    = 4'h9,
    OP_SHLN   = 4'hA,
    OP_RORN   = 4'hB,
    OP_MUL    = 4'hC,
    OP_RSVD_D = 4'hD,
    OP_RSVD_E = 4'hE,
    OP_RSVD_F = 4'hF
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Group membership tables, bit i set when opcode i belongs to the group
  localparam logic [15:0] GRP_SINGLE = 16'h03FF;
  localparam logic [15:0] GRP_SHIFTN = 16'h0C00;
  localparam logic [15:0] GRP_MUL    = 16'h1000;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative radix-2 shift-add unsigned multiplier, one multiplier bit per cycle.
// prod_c/done_c expose the value being written on the final step so the caller can finish on that edge.
module alu_mul_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done_c,
  output logic [2*WIDTH-1:0] prod_c
);
  localparam int unsigned CW = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [CW-1:0]    cnt;
  logic             busy;
  logic [WIDTH:0]   sum;

  // Add multiplicand into the high half when the current multiplier bit is set, then shift right
  always_comb begin
    sum    = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
    prod_c = {sum, lo[WIDTH-1:1]};
    done_c = busy && (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
    end else if (start) begin
      mcand <= a;
      hi    <= '0;
      lo    <= b;
      cnt   <= '0;
      busy  <= 1'b1;
    end else if (busy) begin
      {hi, lo} <= prod_c;
      cnt      <= cnt + CW'(1);
      if (done_c) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with carry chaining, multi-cycle shifts/rotates and optional MUL.
// Define ALU_MUL_EN to build the iterative multiplier; otherwise MUL decodes as reserved.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_n,
  output logic             flag_v,
  output logic             out_err
);
  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned SW  = WIDTH + 1;
  localparam int unsigned MSB = WIDTH - 1;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  state_e           state;
  op_e              opc;
  op_e              opc_in;
  logic [WIDTH-1:0] opa;
  logic [SHW-1:0]   cnt;
  logic [SHW-1:0]   amt;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res_c;
  logic [WIDTH-1:0] sh_nxt;
  logic             c_c, v_c, sh_c;
  logic             accept, is_single, is_shn, is_mul, err_c, go_exec;
  logic             mul_done_c;
  logic [2*WIDTH-1:0] mul_prod_c;

  assign opc_in    = op_e'(op);
  assign accept    = in_valid && in_ready;
  assign amt       = b[SHW-1:0];
  assign is_single = GRP_SINGLE[op];
  assign is_shn    = GRP_SHIFTN[op];
  assign is_mul    = GRP_MUL[op];
  assign err_c     = !(is_single || is_shn || (is_mul && MUL_EN));
  assign go_exec   = (is_shn && (amt != '0)) || (is_mul && MUL_EN);

`ifdef ALU_MUL_EN
  logic mul_start;
  assign mul_start = accept && is_mul;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (mul_start),
    .a      (a),
    .b      (b),
    .done_c (mul_done_c),
    .prod_c (mul_prod_c)
  );
`else
  assign mul_done_c = 1'b0;
  assign mul_prod_c = '0;
`endif

  // Single-cycle datapath straight from the port operands; carry-in for ADC/SBC is the held C flag
  always_comb begin
    sum   = '0;
    res_c = '0;
    c_c   = flag_c;
    v_c   = 1'b0;
    case (opc_in)
      OP_ADD, OP_ADC: begin
        sum   = {1'b0, a} + {1'b0, b} + ((opc_in == OP_ADC) ? SW'(flag_c) : '0);
        res_c = sum[WIDTH-1:0];
        c_c   = sum[WIDTH];
        v_c   = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      OP_SUB, OP_SBC: begin
        sum   = {1'b0, a} - {1'b0, b} - ((opc_in == OP_SBC) ? SW'(flag_c) : '0);
        res_c = sum[WIDTH-1:0];
        c_c   = sum[WIDTH];
        v_c   = (a[MSB] != b[MSB]) && (sum[MSB] != a[MSB]);
      end
      OP_SHL1: begin
        res_c = {a[WIDTH-2:0], 1'b0};
        c_c   = a[MSB];
      end
      OP_ROR1:        res_c = {a[0], a[WIDTH-1:1]};
      OP_AND:         res_c = a & b;
      OP_OR:          res_c = a | b;
      OP_XOR:         res_c = a ^ b;
      OP_NOT:         res_c = ~a;
      OP_SHLN, OP_RORN: res_c = a;
      default:        res_c = '0;
    endcase
  end

  // One-bit step of the captured operand while iterating SHLN/RORN
  always_comb begin
    sh_nxt = {opa[0], opa[WIDTH-1:1]};
    sh_c   = flag_c;
    if (opc == OP_SHLN) begin
      sh_nxt = {opa[WIDTH-2:0], 1'b0};
      sh_c   = opa[MSB];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      flag_n    <= 1'b0;
      flag_v    <= 1'b0;
      out_err   <= 1'b0;
      opa       <= '0;
      opc       <= OP_ADD;
      cnt       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            in_ready <= 1'b0;
            opa      <= a;
            opc      <= opc_in;
            cnt      <= amt;
            if (go_exec) begin
              state <= ST_EXEC;
            end else begin
              state     <= ST_DONE;
              out_valid <= 1'b1;
              result    <= res_c;
              result_hi <= '0;
              out_err   <= err_c;
              if (!err_c) begin
                flag_z <= (res_c == '0);
                flag_c <= c_c;
                flag_n <= res_c[MSB];
                flag_v <= v_c;
              end
            end
          end
        end
        ST_EXEC: begin
          if (opc == OP_MUL) begin
            if (mul_done_c) begin
              state     <= ST_DONE;
              out_valid <= 1'b1;
              out_err   <= 1'b0;
              result    <= mul_prod_c[WIDTH-1:0];
              result_hi <= mul_prod_c[2*WIDTH-1:WIDTH];
              flag_z    <= (mul_prod_c[WIDTH-1:0] == '0);
              flag_c    <= |mul_prod_c[2*WIDTH-1:WIDTH];
              flag_n    <= mul_prod_c[MSB];
              flag_v    <= 1'b0;
            end
          end else begin
            opa <= sh_nxt;
            cnt <= cnt - SHW'(1);
            if (cnt == SHW'(1)) begin
              state     <= ST_DONE;
              out_valid <= 1'b1;
              out_err   <= 1'b0;
              result    <= sh_nxt;
              result_hi <= '0;
              flag_z    <= (sh_nxt == '0);
              flag_c    <= sh_c;
              flag_n    <= sh_nxt[MSB];
              flag_v    <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8 and WIDTH=16; expectations follow ALU_MUL_EN.
// Latency is counted so that an output visible right after the accept edge is 1 cycle.
module tb_alu_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       iv8 = 1'b0, ir8, ov8, ordy8 = 1'b1, z8, c8, n8, v8, e8;
  logic [3:0] op8 = 4'h0;
  logic [7:0] a8 = 8'h00, b8 = 8'h00, r8, rh8;

  logic        iv16 = 1'b0, ir16, ov16, ordy16 = 1'b1, z16, c16, n16, v16, e16;
  logic [3:0]  op16 = 4'h0;
  logic [15:0] a16 = 16'h0, b16 = 16'h0, r16, rh16;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .op(op8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(ordy8), .result(r8), .result_hi(rh8),
    .flag_z(z8), .flag_c(c8), .flag_n(n8), .flag_v(v8), .out_err(e8)
  );

  alu_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .op(op16), .a(a16), .b(b16),
    .out_valid(ov16), .out_ready(ordy16), .result(r16), .result_hi(rh16),
    .flag_z(z16), .flag_c(c16), .flag_n(n16), .flag_v(v16), .out_err(e16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one op with out_ready high, check latency, outputs, flags {z,c,n,v}, then handshake
  task automatic run_op(input bit w16, input string tag, input logic [3:0] o,
                        input logic [15:0] x, input logic [15:0] y, input int lat,
                        input logic [15:0] er, input logic [15:0] erh,
                        input logic [3:0] ef, input logic ee);
    int cyc;
    @(negedge clk);
    if (w16) begin op16 = o; a16 = x; b16 = y; iv16 = 1'b1; end
    else begin op8 = o; a8 = x[7:0]; b8 = y[7:0]; iv8 = 1'b1; end
    chk({tag, " in_ready"}, 32'(w16 ? ir16 : ir8), 32'd1);
    @(posedge clk); #1;
    iv8 = 1'b0; iv16 = 1'b0;
    a8 = ~a8; b8 = ~b8; a16 = ~a16; b16 = ~b16;
    cyc = 1;
    while (!(w16 ? ov16 : ov8) && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, " latency"}, 32'(cyc), 32'(lat));
    chk({tag, " result"}, 32'(w16 ? r16 : {8'h00, r8}), 32'(er));
    chk({tag, " result_hi"}, 32'(w16 ? rh16 : {8'h00, rh8}), 32'(erh));
    chk({tag, " flags"}, 32'(w16 ? {z16, c16, n16, v16} : {z8, c8, n8, v8}), 32'(ef));
    chk({tag, " err"}, 32'(w16 ? e16 : e8), 32'(ee));
    @(posedge clk); #1;
    chk({tag, " out_valid drop"}, 32'(w16 ? ov16 : ov8), 32'd0);
    chk({tag, " in_ready back"}, 32'(w16 ? ir16 : ir8), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst in_ready8", 32'(ir8), 32'd1);
    chk("rst out_valid8", 32'(ov8), 32'd0);
    chk("rst result8", 32'({rh8, r8}), 32'd0);
    chk("rst flags8", 32'({z8, c8, n8, v8, e8}), 32'd0);
    chk("rst in_ready16", 32'(ir16), 32'd1);
    chk("rst outs16", 32'({ov16, e16, z16, c16, n16, v16, rh16, r16}), 32'd0);

    run_op(0, "add8",   4'h0, 16'h00FF, 16'h0001, 1, 16'h0000, 16'h0, 4'b1100, 1'b0);
    run_op(0, "adc8",   4'h8, 16'h0000, 16'h0000, 1, 16'h0001, 16'h0, 4'b0000, 1'b0);
    run_op(0, "sub8",   4'h1, 16'h0000, 16'h0001, 1, 16'h00FF, 16'h0, 4'b0110, 1'b0);
    run_op(0, "sbc8",   4'h9, 16'h0010, 16'h0005, 1, 16'h000A, 16'h0, 4'b0000, 1'b0);
    run_op(0, "shln8",  4'hA, 16'h0081, 16'h0003, 4, 16'h0008, 16'h0, 4'b0000, 1'b0);
    run_op(0, "shl1_8", 4'h2, 16'h0080, 16'h0000, 1, 16'h0000, 16'h0, 4'b1100, 1'b0);
    run_op(0, "rorn8",  4'hB, 16'h0001, 16'h0001, 2, 16'h0080, 16'h0, 4'b0110, 1'b0);
    run_op(0, "ror1_8", 4'h3, 16'h0003, 16'h0000, 1, 16'h0081, 16'h0, 4'b0110, 1'b0);
    run_op(0, "and8",   4'h4, 16'h00F0, 16'h003C, 1, 16'h0030, 16'h0, 4'b0100, 1'b0);
    run_op(0, "addv8",  4'h0, 16'h007F, 16'h0001, 1, 16'h0080, 16'h0, 4'b0011, 1'b0);
    run_op(0, "not8",   4'h7, 16'h000F, 16'h0000, 1, 16'h00F0, 16'h0, 4'b0010, 1'b0);
`ifdef ALU_MUL_EN
    run_op(0, "mul8",   4'hC, 16'h00FF, 16'h00FF, 9, 16'h0001, 16'h00FE, 4'b0100, 1'b0);
    run_op(0, "rsvd8",  4'hD, 16'h0012, 16'h0034, 1, 16'h0000, 16'h0, 4'b0100, 1'b1);
    run_op(0, "shln0_8", 4'hA, 16'h005A, 16'h0008, 1, 16'h005A, 16'h0, 4'b0100, 1'b0);
`else
    run_op(0, "mul8",   4'hC, 16'h00FF, 16'h00FF, 1, 16'h0000, 16'h0000, 4'b0010, 1'b1);
    run_op(0, "rsvd8",  4'hD, 16'h0012, 16'h0034, 1, 16'h0000, 16'h0, 4'b0010, 1'b1);
    run_op(0, "shln0_8", 4'hA, 16'h005A, 16'h0008, 1, 16'h005A, 16'h0, 4'b0000, 1'b0);
`endif

    // Backpressure: result held while a second request waits
    @(negedge clk);
    ordy8 = 1'b0; op8 = 4'h6; a8 = 8'hF0; b8 = 8'hFF; iv8 = 1'b1;
    @(posedge clk); #1;
    op8 = 4'h0; a8 = 8'h01; b8 = 8'h01;
    chk("bp out_valid", 32'(ov8), 32'd1);
    chk("bp result", 32'(r8), 32'h0F);
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp hold out_valid", 32'(ov8), 32'd1);
      chk("bp hold result", 32'(r8), 32'h0F);
      chk("bp hold in_ready", 32'(ir8), 32'd0);
    end
    @(negedge clk);
    iv8 = 1'b0; ordy8 = 1'b1;
    @(posedge clk); #1;
    chk("bp release out_valid", 32'(ov8), 32'd0);
    chk("bp release in_ready", 32'(ir8), 32'd1);
    @(posedge clk); #1;
    chk("bp second not taken", 32'({ov8, r8}), 32'h0F);

    // Reset in the middle of a multi-cycle MUL
    @(negedge clk);
    op8 = 4'hC; a8 = 8'hFF; b8 = 8'hFF; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    repeat (3) begin
`ifdef ALU_MUL_EN
      chk("mulrst pre out_valid", 32'(ov8), 32'd0);
`endif
      @(posedge clk); #1;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mulrst in_ready", 32'(ir8), 32'd1);
    chk("mulrst outs", 32'({ov8, e8, z8, c8, n8, v8, rh8, r8}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      seen = seen | ov8;
    end
    chk("mulrst no output", 32'(seen), 32'd0);
    run_op(0, "add_after_rst", 4'h0, 16'h0001, 16'h0002, 1, 16'h0003, 16'h0, 4'b0000, 1'b0);

    run_op(1, "add16",  4'h0, 16'hFFFF, 16'h0001, 1, 16'h0000, 16'h0, 4'b1100, 1'b0);
    run_op(1, "adc16",  4'h8, 16'h0000, 16'h0000, 1, 16'h0001, 16'h0, 4'b0000, 1'b0);
    run_op(1, "sub16",  4'h1, 16'h8000, 16'h0001, 1, 16'h7FFF, 16'h0, 4'b0001, 1'b0);
    run_op(1, "shln16", 4'hA, 16'h8001, 16'h0004, 5, 16'h0010, 16'h0, 4'b0000, 1'b0);
    run_op(1, "rorn16", 4'hB, 16'h0001, 16'h000F, 16, 16'h0002, 16'h0, 4'b0000, 1'b0);
`ifdef ALU_MUL_EN
    run_op(1, "mul16",  4'hC, 16'hFFFF, 16'hFFFF, 17, 16'h0001, 16'hFFFE, 4'b0100, 1'b0);
`else
    run_op(1, "mul16",  4'hC, 16'hFFFF, 16'hFFFF, 1, 16'h0000, 16'h0000, 4'b0000, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
